// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multi-cycle MULT/DIV sequencer holding the architectural HI/LO registers
// Fixed-latency: results are computed from latched operands and committed on the final busy edge.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    op_q, op_n;
  logic [31:0]   a_q, a_n, b_q, b_n;
  logic [31:0]   hi_n, lo_n;

  logic          long_op, mul_cmd;
  logic          is_signed, is_mul;
  logic [63:0]   ext_a, ext_b, prod;
  logic          neg_a, neg_b;
  logic [31:0]   mag_a, mag_b, div_b, q_mag, r_mag, quo, rem;

  assign long_op  = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
  assign mul_cmd  = (md_op == OP_MULT) || (md_op == OP_MULTU);
  assign busy     = (state == RUN);
  assign md_stall = busy | (start & long_op);

  // Sign-extending to 64 bits lets one unsigned multiplier serve both MULT and MULTU.
  assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
  assign is_mul    = (op_q == OP_MULT) || (op_q == OP_MULTU);
  assign ext_a     = is_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign ext_b     = is_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign prod      = ext_a * ext_b;

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 with no overflow trap.
  assign neg_a = is_signed & a_q[31];
  assign neg_b = is_signed & b_q[31];
  assign mag_a = neg_a ? (~a_q + 32'd1) : a_q;
  assign mag_b = neg_b ? (~b_q + 32'd1) : b_q;
  assign div_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign q_mag = mag_a / div_b;
  assign r_mag = mag_a % div_b;
  assign quo   = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
  assign rem   = neg_a ? (~r_mag + 32'd1) : r_mag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= 3'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      op_q  <= op_n;
      a_q   <= a_n;
      b_q   <= b_n;
      hi    <= hi_n;
      lo    <= lo_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_q;
    a_n     = a_q;
    b_n     = b_q;
    hi_n    = hi;
    lo_n    = lo;
    if (state == IDLE) begin
      if (start) begin
        if (long_op) begin
          state_n = RUN;
          cnt_n   = mul_cmd ? MULT_LOAD : DIV_LOAD;
          op_n    = md_op;
          a_n     = in_a;
          b_n     = in_b;
        end else if (md_op == OP_MTHI) begin
          hi_n = in_a;
        end else if (md_op == OP_MTLO) begin
          lo_n = in_a;
        end
      end
    end else begin
      cnt_n = cnt - CNT_ONE;
      if (cnt == CNT_ONE) begin
        state_n = IDLE;
        if (is_mul) begin
          hi_n = prod[63:32];
          lo_n = prod[31:0];
        end else if (b_q != 32'd0) begin
          hi_n = rem;
          lo_n = quo;
        end
      end
    end
  end

endmodule
